// File: rtl/pipelined_instr_decoder_pkg.sv
// Shared definitions for the instruction decode stage.
//   - Opcode constants for the jump and branch instructions.
//   - FORMAT encodings driven on the decoded-fields bus.
//   - Bit positions of the register-address fields in the instruction word.
//   - Width helper for the flat decoded-fields bus that the decode and
//     holding registers pass around.
package pipelined_instr_decoder_pkg;

    localparam logic [7:0] OP_JUMP = 8'h06;
    localparam logic [7:0] OP_BEQ  = 8'h07;
    localparam logic [7:0] OP_BNE  = 8'h0C;

    typedef enum logic [1:0] {
        FMT_ALU    = 2'd0,
        FMT_JUMP   = 2'd1,
        FMT_BRANCH = 2'd2,
        FMT_RSVD   = 2'd3
    } format_e;

    localparam int RR1_LSB = 8;
    localparam int RR2_LSB = 0;
    localparam int WR_LSB  = 16;

    // Bus layout, MSB first:
    // {opcode, readreg1, readreg2, writereg, immediate, offset, format, branch_ne, illegal}
    function automatic int dec_bus_width(input int opw, input int rw,
                                         input int immw, input int offw);
        return opw + 3 * rw + immw + offw + 2 + 1 + 1;
    endfunction

endpackage

// File: rtl/pipelined_instr_decoder_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and
// the register file / control consumer.
//   Fetch side   : IN_VALID, IN_READY, INSTRUCTION, FLUSH
//   Consumer side: OUT_VALID, OUT_READY, OPCODE, READREG1, READREG2, WRITEREG,
//                  IMMEDIATE, OFFSET, FORMAT, BRANCH_NE, ILLEGAL
// Modports:
//   slave  - the decode stage
//   master - whatever drives fetch and consumes the decoded fields
interface pipelined_instr_decoder_if #(
    parameter int INSTR_WIDTH    = 32,
    parameter int OPCODE_WIDTH   = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int IMM_WIDTH      = 8,
    parameter int OFFSET_WIDTH   = 8
) ();

    logic                      IN_VALID;
    logic                      IN_READY;
    logic [INSTR_WIDTH-1:0]    INSTRUCTION;
    logic                      FLUSH;

    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [OPCODE_WIDTH-1:0]   OPCODE;
    logic [REG_ADDR_WIDTH-1:0] READREG1;
    logic [REG_ADDR_WIDTH-1:0] READREG2;
    logic [REG_ADDR_WIDTH-1:0] WRITEREG;
    logic [IMM_WIDTH-1:0]      IMMEDIATE;
    logic [OFFSET_WIDTH-1:0]   OFFSET;
    logic [1:0]                FORMAT;
    logic                      BRANCH_NE;
    logic                      ILLEGAL;

    modport slave (
        input  IN_VALID, INSTRUCTION, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OPCODE, READREG1, READREG2, WRITEREG,
               IMMEDIATE, OFFSET, FORMAT, BRANCH_NE, ILLEGAL
    );

    modport master (
        output IN_VALID, INSTRUCTION, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OPCODE, READREG1, READREG2, WRITEREG,
               IMMEDIATE, OFFSET, FORMAT, BRANCH_NE, ILLEGAL
    );

endinterface

// File: rtl/pipelined_instr_decoder_decode_fields.sv
// Pure combinational split of one instruction word into its decoded fields.
//   instr_i  : instruction word
//   fields_o : flat decoded-fields bus (layout in the package)
// Fields that the instruction format does not use are forced to zero.
module decode_fields
    import pipelined_instr_decoder_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int OPCODE_WIDTH   = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int IMM_WIDTH      = 8,
    parameter int OFFSET_WIDTH   = 8,
    parameter int NUM_OPCODES    = 13,
    localparam int DEC_W = dec_bus_width(OPCODE_WIDTH, REG_ADDR_WIDTH, IMM_WIDTH, OFFSET_WIDTH)
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    output logic [DEC_W-1:0]       fields_o
);

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] rr1;
    logic [REG_ADDR_WIDTH-1:0] rr2;
    logic [REG_ADDR_WIDTH-1:0] wr;
    logic [IMM_WIDTH-1:0]      imm;
    logic [OFFSET_WIDTH-1:0]   off;
    format_e                   fmt;
    logic                      bne;
    logic                      illegal;
    // Some instruction bits belong to no field; fold them here so the
    // unused-bit intent is explicit.
    logic                      unused_bits;

    assign opcode      = instr_i[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign illegal     = $unsigned(32'(opcode)) >= $unsigned(32'(NUM_OPCODES));
    assign unused_bits = ^instr_i;

    always_comb begin
        rr1 = '0;
        rr2 = '0;
        wr  = '0;
        imm = '0;
        off = '0;
        fmt = FMT_ALU;
        bne = 1'b0;
        if (opcode == OPCODE_WIDTH'(OP_JUMP)) begin
            off = instr_i[INSTR_WIDTH-OPCODE_WIDTH-1 -: OFFSET_WIDTH];
            fmt = FMT_JUMP;
        end else if (opcode == OPCODE_WIDTH'(OP_BEQ) || opcode == OPCODE_WIDTH'(OP_BNE)) begin
            off = instr_i[INSTR_WIDTH-OPCODE_WIDTH-1 -: OFFSET_WIDTH];
            rr1 = instr_i[RR1_LSB +: REG_ADDR_WIDTH];
            rr2 = instr_i[RR2_LSB +: REG_ADDR_WIDTH];
            fmt = FMT_BRANCH;
            bne = (opcode == OPCODE_WIDTH'(OP_BNE));
        end else begin
            // Illegal opcodes also land here and decode as ALU/imm/mem.
            imm = instr_i[IMM_WIDTH-1:0];
            rr1 = instr_i[RR1_LSB +: REG_ADDR_WIDTH];
            rr2 = instr_i[RR2_LSB +: REG_ADDR_WIDTH];
            wr  = instr_i[WR_LSB +: REG_ADDR_WIDTH];
        end
    end

    assign fields_o = {opcode, rr1, rr2, wr, imm, off, fmt, bne, illegal};

endmodule

// File: rtl/pipelined_instr_decoder.sv
// Registered instruction decode stage with a 2-entry skid buffer.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-low reset
//   bus   : slave view of the fetch/consumer handshake and decoded fields
// The word is decoded on the input side; the stage holds an output entry and
// a skid entry. IN_READY is registered so it never depends on OUT_READY in the
// same cycle; the skid entry absorbs the one word accepted during a stall.
module pipelined_instr_decoder
    import pipelined_instr_decoder_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int OPCODE_WIDTH   = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int IMM_WIDTH      = 8,
    parameter int OFFSET_WIDTH   = 8,
    parameter int NUM_OPCODES    = 13
) (
    input  logic                     CLK,
    input  logic                     RESET,
    pipelined_instr_decoder_if.slave bus
);

    localparam int DEC_W = dec_bus_width(OPCODE_WIDTH, REG_ADDR_WIDTH, IMM_WIDTH, OFFSET_WIDTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [DEC_W-1:0] dec_fields;
    logic [DEC_W-1:0] out_q, out_d;
    logic [DEC_W-1:0] skid_q, skid_d;
    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             drain;

    decode_fields #(
        .INSTR_WIDTH   (INSTR_WIDTH),
        .OPCODE_WIDTH  (OPCODE_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .IMM_WIDTH     (IMM_WIDTH),
        .OFFSET_WIDTH  (OFFSET_WIDTH),
        .NUM_OPCODES   (NUM_OPCODES)
    ) u_decode_fields (
        .instr_i (bus.INSTRUCTION),
        .fields_o(dec_fields)
    );

    assign accept = bus.IN_VALID && in_ready_q;
    assign drain  = (state_q != ST_EMPTY) && bus.OUT_READY;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (bus.FLUSH) begin
            // Flush wins over accept and drain alike.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = dec_fields;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = dec_fields;
                    end else if (accept) begin
                        skid_d  = dec_fields;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // IN_READY is low here, so only a drain can move us.
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = (state_q != ST_EMPTY);
    assign {bus.OPCODE, bus.READREG1, bus.READREG2, bus.WRITEREG,
            bus.IMMEDIATE, bus.OFFSET, bus.FORMAT, bus.BRANCH_NE, bus.ILLEGAL} = out_q;

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Scoreboard bench for pipelined_instr_decoder: expected decodes are queued
// at each input handshake and popped at each output handshake.
module tb_pipelined_instr_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_instr_decoder_if #(
        .INSTR_WIDTH(32), .OPCODE_WIDTH(8), .REG_ADDR_WIDTH(3),
        .IMM_WIDTH(8), .OFFSET_WIDTH(8)
    ) bus ();

    pipelined_instr_decoder #(
        .INSTR_WIDTH(32), .OPCODE_WIDTH(8), .REG_ADDR_WIDTH(3),
        .IMM_WIDTH(8), .OFFSET_WIDTH(8), .NUM_OPCODES(13)
    ) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [7:0] op;
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic [2:0] wr;
        logic [7:0] imm;
        logic [7:0] off;
        logic [1:0] fmt;
        logic       bne;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference decode written from the instruction-format description.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e = '0;
        e.op  = w[31:24];
        e.ill = (w[31:24] > 8'd12);
        case (w[31:24])
            8'h06: begin
                e.off = w[23:16];
                e.fmt = 2'd1;
            end
            8'h07, 8'h0C: begin
                e.off = w[23:16];
                e.rr1 = w[10:8];
                e.rr2 = w[2:0];
                e.fmt = 2'd2;
                e.bne = (w[31:24] == 8'h0C);
            end
            default: begin
                e.imm = w[7:0];
                e.rr1 = w[10:8];
                e.rr2 = w[2:0];
                e.wr  = w[18:16];
            end
        endcase
        return e;
    endfunction

    function automatic exp_t observe();
        return {bus.OPCODE, bus.READREG1, bus.READREG2, bus.WRITEREG,
                bus.IMMEDIATE, bus.OFFSET, bus.FORMAT, bus.BRANCH_NE, bus.ILLEGAL};
    endfunction

    // Called at a falling edge with inputs already driven; resolves the
    // handshakes of the coming rising edge and returns at the next falling edge.
    task automatic tick(output logic accepted);
        exp_t e;
        #1;
        accepted = 1'b0;
        if (bus.FLUSH) begin
            sb_q.delete();
        end else begin
            if (bus.OUT_VALID && bus.OUT_READY) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h expected=<nothing>", observe());
                end else begin
                    e = sb_q.pop_front();
                    if (observe() !== e) begin
                        failures++;
                        $display("FAIL sb_data got=%h expected=%h", observe(), e);
                    end
                end
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                sb_q.push_back(model(bus.INSTRUCTION));
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got=%b%b expected=00", bus.IN_READY, bus.OUT_VALID);
        end
        checks++;
        if (observe() !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_fields got=%h expected=0", observe());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_early got=%b expected=0", bus.IN_READY);
        end
        @(negedge clk);
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b%b expected=10", bus.IN_READY, bus.OUT_VALID);
        end
    endtask

    task automatic test_alu();
        logic acc;
        bus.OUT_READY   = 1'b1;
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'h0002_0301;
        tick(acc);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b1) begin
            failures++;
            $display("FAIL alu_latency got=%b expected=1", bus.OUT_VALID);
        end
        checks++;
        if (observe() !== exp_t'{op:8'h00, rr1:3'd3, rr2:3'd1, wr:3'd2, imm:8'h01,
                                 off:8'h00, fmt:2'd0, bne:1'b0, ill:1'b0}) begin
            failures++;
            $display("FAIL alu_fields got=%h", observe());
        end
        tick(acc);
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL alu_drain got=%b expected=0", bus.OUT_VALID);
        end
    endtask

    task automatic test_jump_branch();
        logic acc;
        bus.OUT_READY   = 1'b1;
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'h06FC_0000;
        tick(acc);
        bus.INSTRUCTION = 32'h0C05_0102;
        checks++;
        if (observe() !== exp_t'{op:8'h06, rr1:3'd0, rr2:3'd0, wr:3'd0, imm:8'h00,
                                 off:8'hFC, fmt:2'd1, bne:1'b0, ill:1'b0}) begin
            failures++;
            $display("FAIL jump_fields got=%h", observe());
        end
        tick(acc);
        bus.IN_VALID = 1'b0;
        checks++;
        if (observe() !== exp_t'{op:8'h0C, rr1:3'd1, rr2:3'd2, wr:3'd0, imm:8'h00,
                                 off:8'h05, fmt:2'd2, bne:1'b1, ill:1'b0}) begin
            failures++;
            $display("FAIL bne_fields got=%h", observe());
        end
        tick(acc);
    endtask

    task automatic test_illegal();
        logic acc;
        bus.OUT_READY   = 1'b1;
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'hFF12_3456;
        tick(acc);
        bus.INSTRUCTION = 32'h0C00_0000;
        checks++;
        if (observe() !== exp_t'{op:8'hFF, rr1:3'd4, rr2:3'd6, wr:3'd2, imm:8'h56,
                                 off:8'h00, fmt:2'd0, bne:1'b0, ill:1'b1}) begin
            failures++;
            $display("FAIL illegal_ff got=%h", observe());
        end
        tick(acc);
        bus.INSTRUCTION = 32'h0D00_0000;
        checks++;
        if (bus.ILLEGAL !== 1'b0 || bus.FORMAT !== 2'd2) begin
            failures++;
            $display("FAIL legal_0c got=%b/%0d expected=0/2", bus.ILLEGAL, bus.FORMAT);
        end
        tick(acc);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.ILLEGAL !== 1'b1 || bus.OPCODE !== 8'h0D) begin
            failures++;
            $display("FAIL illegal_0d got=%b/%h expected=1/0d", bus.ILLEGAL, bus.OPCODE);
        end
        tick(acc);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        int          idx;
        logic        acc;
        logic        prev_stall;
        exp_t        snap;
        words[0] = 32'h0312_0405;
        words[1] = 32'h0780_0706;
        words[2] = 32'h0C7F_0501;
        words[3] = 32'h0655_0000;
        idx = 0;
        prev_stall = 1'b0;
        snap = '0;
        for (int cyc = 0; cyc < 30 && (idx < 4 || sb_q.size() > 0); cyc++) begin
            bus.OUT_READY   = (cyc >= 3);
            bus.IN_VALID    = (idx < 4);
            bus.INSTRUCTION = (idx < 4) ? words[idx] : 32'h0;
            if (prev_stall) begin
                checks++;
                if (observe() !== snap) begin
                    failures++;
                    $display("FAIL stall_stable cyc=%0d got=%h expected=%h", cyc, observe(), snap);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (bus.IN_READY !== 1'b0) begin
                    failures++;
                    $display("FAIL skid_full_ready got=%b expected=0", bus.IN_READY);
                end
            end
            prev_stall = bus.OUT_VALID && !bus.OUT_READY;
            snap = observe();
            tick(acc);
            if (acc) idx++;
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (idx != 4 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_complete got=accepted %0d pending %0d expected=accepted 4 pending 0",
                     idx, sb_q.size());
        end
    endtask

    task automatic test_flush();
        logic acc;
        bus.OUT_READY   = 1'b0;
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'h0100_0102;
        tick(acc);
        bus.INSTRUCTION = 32'h0201_0203;
        tick(acc);
        bus.INSTRUCTION = 32'h0302_0304;
        bus.FLUSH       = 1'b1;
        tick(acc);
        bus.FLUSH    = 1'b0;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL flush_full got=%b%b expected=01", bus.OUT_VALID, bus.IN_READY);
        end
        // Flush while an input really handshakes.
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'h0403_0405;
        tick(acc);
        bus.INSTRUCTION = 32'h0504_0506;
        bus.FLUSH       = 1'b1;
        tick(acc);
        bus.FLUSH = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL flush_one got=%b%b expected=01", bus.OUT_VALID, bus.IN_READY);
        end
        bus.OUT_READY   = 1'b1;
        bus.INSTRUCTION = 32'h0203_0405;
        tick(acc);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b1 ||
            observe() !== exp_t'{op:8'h02, rr1:3'd4, rr2:3'd5, wr:3'd3, imm:8'h05,
                                 off:8'h00, fmt:2'd0, bne:1'b0, ill:1'b0}) begin
            failures++;
            $display("FAIL flush_after got=%b/%h", bus.OUT_VALID, observe());
        end
        tick(acc);
        checks++;
        if (bus.OUT_VALID !== 1'b0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL flush_leftover got=%b/%0d expected=0/0", bus.OUT_VALID, sb_q.size());
        end
    endtask

    task automatic test_reset_midop();
        logic acc;
        bus.OUT_READY   = 1'b0;
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'h0111_0111;
        tick(acc);
        bus.INSTRUCTION = 32'h0222_0222;
        tick(acc);
        bus.IN_VALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b0 || observe() !== exp_t'(0)) begin
            failures++;
            $display("FAIL async_reset got=%b%b/%h expected=00/0", bus.IN_READY, bus.OUT_VALID, observe());
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL midop_ready_early got=%b expected=0", bus.IN_READY);
        end
        @(negedge clk);
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL midop_release got=%b%b expected=10", bus.IN_READY, bus.OUT_VALID);
        end
        bus.OUT_READY   = 1'b1;
        bus.IN_VALID    = 1'b1;
        bus.INSTRUCTION = 32'h0A05_0607;
        tick(acc);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b1 ||
            observe() !== exp_t'{op:8'h0A, rr1:3'd6, rr2:3'd7, wr:3'd5, imm:8'h07,
                                 off:8'h00, fmt:2'd0, bne:1'b0, ill:1'b0}) begin
            failures++;
            $display("FAIL midop_decode got=%b/%h", bus.OUT_VALID, observe());
        end
        tick(acc);
    endtask

    initial begin
        bus.IN_VALID    = 1'b0;
        bus.INSTRUCTION = 32'h0;
        bus.FLUSH       = 1'b0;
        bus.OUT_READY   = 1'b0;
        #2;
        test_reset();
        test_alu();
        test_jump_branch();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
